// File: rtl/all_types_pkg.sv
// ============================================================================
//  Package     : all_types_pkg
//  Description : Shared enumerations used to configure the parity checker.
//                parity_mode_e   - parity the whole word must carry.
//                parity_bit_e    - position of the parity bit in the word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package all_types_pkg;

  typedef enum logic {
    ODD  = 1'b0,
    EVEN = 1'b1
  } parity_mode_e;

  typedef enum logic {
    MSB = 1'b0,
    LSB = 1'b1
  } parity_bit_e;

endpackage : all_types_pkg

`default_nettype wire

// File: rtl/parity_checker_core.sv
// ============================================================================
//  Module      : parity_checker_core
//  Description : Zero-latency parity filter between a FIFO pop port and a
//                consumer. Words with correct parity are offered through a
//                valid/grant handshake and stay in the FIFO until granted.
//                Words with wrong parity are popped at once and discarded,
//                and each discard is reported on a one-cycle pulse and a
//                saturating counter.
//  Ports       : clk_i        - clock, rising edge
//                rst_i        - synchronous reset, active high
//                pop_valid_i  - FIFO presents a word
//                pop_data_i   - FIFO word (payload plus parity bit)
//                pop_grant_o  - pop request to the FIFO (word consumed)
//                grant_i      - consumer accepts the current good word
//                valid_o      - good word available to the consumer
//                err_o        - pulse: a word was dropped last cycle
//                err_count_o  - saturating count of dropped words
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_checker_core #(
  parameter int                          DATA_WIDTH        = 8,
  parameter all_types_pkg::parity_mode_e PARITY_MODE       = all_types_pkg::ODD,
  parameter all_types_pkg::parity_bit_e  PARITY_BIT_CHOICE = all_types_pkg::MSB,
  parameter int                          ERR_CNT_WIDTH     = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     pop_valid_i,
  input  logic [DATA_WIDTH-1:0]    pop_data_i,
  output logic                     pop_grant_o,
  input  logic                     grant_i,
  output logic                     valid_o,
  output logic                     err_o,
  output logic [ERR_CNT_WIDTH-1:0] err_count_o
);

  // Position of the parity bit. The check covers every bit of the word, so
  // this only splits the word into payload and parity bit; the result of
  // the check is the same for either choice.
  localparam int PAR_IDX = (PARITY_BIT_CHOICE == all_types_pkg::MSB) ? DATA_WIDTH - 1 : 0;
  localparam logic [DATA_WIDTH-1:0] PAR_MASK =
    {{(DATA_WIDTH-1){1'b0}}, 1'b1} << PAR_IDX;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE   = {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};

  logic payload_xor;
  logic parity_bit;
  logic word_odd;
  logic parity_ok;
  logic good;
  logic drop;

  logic                     err_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;

  // ---------------------------------------------------------------------
  // Parity evaluation: XOR-reduction of the whole word is 1 when the
  // popcount is odd.
  // ---------------------------------------------------------------------
  always_comb begin
    payload_xor = ^(pop_data_i & ~PAR_MASK);
    parity_bit  = pop_data_i[PAR_IDX];
    word_odd    = payload_xor ^ parity_bit;
    parity_ok   = (PARITY_MODE == all_types_pkg::ODD) ? word_odd : ~word_odd;
  end

  // ---------------------------------------------------------------------
  // Handshake (combinational). Reset masks both directions so a word that
  // is pending when reset asserts is neither accepted nor dropped.
  // ---------------------------------------------------------------------
  always_comb begin
    good        = pop_valid_i &  parity_ok & ~rst_i;
    drop        = pop_valid_i & ~parity_ok & ~rst_i;
    valid_o     = good;
    pop_grant_o = (good & grant_i) | drop;
  end

  // ---------------------------------------------------------------------
  // Drop status: one-cycle pulse and saturating counter.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop;
      if (drop && (cnt_q != CNT_MAX)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  assign err_o       = err_q;
  assign err_count_o = cnt_q;

endmodule : parity_checker_core

`default_nettype wire

// File: tb/tb_parity_checker_core.sv
// ============================================================================
//  Module      : tb_parity_checker_core
//  Description : Directed self-checking bench for parity_checker_core.
//                Three instances share one stimulus: ODD/MSB/16-bit count,
//                EVEN/LSB/16-bit count, and ODD/MSB/2-bit count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_checker_core;

  logic       clk;
  logic       rst;
  logic       pop_valid;
  logic [7:0] pop_data;
  logic       grant;

  logic        a_pop_grant, a_valid, a_err;
  logic [15:0] a_cnt;
  logic        e_pop_grant, e_valid, e_err;
  logic [15:0] e_cnt;
  logic        s_pop_grant, s_valid, s_err;
  logic [1:0]  s_cnt;

  int n_cmp = 0;
  int n_err = 0;

  parity_checker_core #(
    .DATA_WIDTH(8), .PARITY_MODE(all_types_pkg::ODD),
    .PARITY_BIT_CHOICE(all_types_pkg::MSB), .ERR_CNT_WIDTH(16)
  ) u_odd (
    .clk_i(clk), .rst_i(rst), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
    .pop_grant_o(a_pop_grant), .grant_i(grant), .valid_o(a_valid),
    .err_o(a_err), .err_count_o(a_cnt)
  );

  parity_checker_core #(
    .DATA_WIDTH(8), .PARITY_MODE(all_types_pkg::EVEN),
    .PARITY_BIT_CHOICE(all_types_pkg::LSB), .ERR_CNT_WIDTH(16)
  ) u_even (
    .clk_i(clk), .rst_i(rst), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
    .pop_grant_o(e_pop_grant), .grant_i(grant), .valid_o(e_valid),
    .err_o(e_err), .err_count_o(e_cnt)
  );

  parity_checker_core #(
    .DATA_WIDTH(8), .PARITY_MODE(all_types_pkg::ODD),
    .PARITY_BIT_CHOICE(all_types_pkg::MSB), .ERR_CNT_WIDTH(2)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .pop_valid_i(pop_valid), .pop_data_i(pop_data),
    .pop_grant_o(s_pop_grant), .grant_i(grant), .valid_o(s_valid),
    .err_o(s_err), .err_count_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    pop_valid = 1'b1;
    pop_data  = 8'h03;
    grant     = 1'b1;

    // Reset with a bad word pending and grant asserted
    cyc();
    check("rst_valid_c1",  a_valid,     0);
    check("rst_pgrant_c1", a_pop_grant, 0);
    cyc();
    check("rst_valid_c2",  a_valid,     0);
    check("rst_pgrant_c2", a_pop_grant, 0);
    check("rst_err",       a_err,       0);
    check("rst_cnt",       a_cnt,       0);
    check("rst_sat_cnt",   s_cnt,       0);

    // Good word, no grant: held for 3 cycles
    rst      = 1'b0;
    pop_data = 8'h01;
    grant    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("hold_valid_%0d", i),  a_valid,     1);
      check($sformatf("hold_pgrant_%0d", i), a_pop_grant, 0);
      cyc();
    end
    check("hold_err", a_err, 0);
    check("hold_cnt", a_cnt, 0);

    // Good word, granted
    grant = 1'b1;
    #1;
    check("grant_valid",  a_valid,     1);
    check("grant_pgrant", a_pop_grant, 1);
    cyc();

    // Bad word without grant
    pop_data = 8'h03;
    grant    = 1'b0;
    #1;
    check("bad_g0_valid",  a_valid,     0);
    check("bad_g0_pgrant", a_pop_grant, 1);
    cyc();
    check("bad_g0_err", a_err, 1);
    check("bad_g0_cnt", a_cnt, 1);

    // Bad word with grant
    grant = 1'b1;
    #1;
    check("bad_g1_valid",  a_valid,     0);
    check("bad_g1_pgrant", a_pop_grant, 1);
    cyc();
    check("bad_g1_err", a_err, 1);
    check("bad_g1_cnt", a_cnt, 2);

    // More good patterns: 7 ones and a lone MSB
    pop_data = 8'hFE;
    grant    = 1'b0;
    #1;
    check("fe_valid", a_valid, 1);
    cyc();
    check("fe_err", a_err, 0);
    check("fe_cnt", a_cnt, 2);
    pop_data = 8'h80;
    #1;
    check("80_valid", a_valid, 1);

    // Idle: no valid, grant high
    pop_valid = 1'b0;
    grant     = 1'b1;
    pop_data  = 8'h03;
    #1;
    check("idle_valid",    a_valid,     0);
    check("idle_pgrant",   a_pop_grant, 0);
    check("idle_e_valid",  e_valid,     0);
    check("idle_e_pgrant", e_pop_grant, 0);
    cyc();
    check("idle_err",   a_err, 0);
    check("idle_e_err", e_err, 0);

    // EVEN mode: 8'h03 good, 8'h01 dropped
    pop_valid = 1'b1;
    #1;
    check("even03_valid",  e_valid,     1);
    check("even03_pgrant", e_pop_grant, 1);
    check("odd03_valid",   a_valid,     0);
    pop_data = 8'h01;
    grant    = 1'b0;
    #1;
    check("even01_valid",  e_valid,     0);
    check("even01_pgrant", e_pop_grant, 1);
    cyc();
    check("even01_err", e_err, 1);

    // Saturation of the 2-bit counter over 5 consecutive bad words
    rst = 1'b1;
    cyc();
    check("sat_rst_cnt", s_cnt, 0);
    rst      = 1'b0;
    pop_data = 8'h03;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("sat_err_%0d", k), s_err, 1);
      check($sformatf("sat_cnt_%0d", k), s_cnt, (k > 3) ? 3 : k);
    end
    pop_valid = 1'b0;
    cyc();
    check("sat_hold_cnt", s_cnt, 3);
    check("sat_hold_err", s_err, 0);
    check("wide_cnt_5",   a_cnt, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_parity_checker_core

`default_nettype wire
